// File: rtl/mux_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_sweep_pkg
// Purpose  : Shared types and constants for the 4:1 mux sweep checker.
// Revision : 1.0 - initial release
// ============================================================================
package mux_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int VEC_W    = 6;
    localparam int NUM_VEC  = 64;

    // A vector index is {sel, data}; sel sits above the four data lines.
    localparam int DATA_LSB = 0;
    localparam int DATA_MSB = 3;
    localparam int SEL_LSB  = 4;
    localparam int SEL_MSB  = 5;

    localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(NUM_VEC - 1);

endpackage : mux_sweep_pkg
`default_nettype wire

// File: rtl/mux4_golden.sv
`default_nettype none
// ============================================================================
// Module   : mux4_golden
// Purpose  : Combinational reference 4:1 multiplexer, y = data[sel].
// Revision : 1.0 - initial release
// ============================================================================
module mux4_golden (
    input  logic [3:0] data,
    input  logic [1:0] sel,
    output logic       y
);

    assign y = data[sel];

endmodule : mux4_golden
`default_nettype wire

// File: rtl/mux_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : mux_sweep_checker
// Purpose  : Drives all 64 {sel,data} vectors into two mux implementations,
//            waits a settle window, and checks both against a golden model.
// Revision : 1.0 - initial release
// ============================================================================
module mux_sweep_checker
    import mux_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [3:0]       data,
    output logic [1:0]       sel,
    input  logic             w_a,
    input  logic             w_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [5:0]       first_fail_vec,
    output logic             first_fail_valid
);

    localparam int TMR_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SETTLE_CYCLES - 1);

    state_t             r_state;
    state_t             w_next;
    logic [TMR_W-1:0]   r_timer;
    logic [VEC_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_err;
    logic [CNT_W-1:0]   w_err_next;
    logic               r_pass;
    logic [5:0]         r_ffvec;
    logic               r_ffvalid;
    logic               w_golden;
    logic               w_mismatch;
    logic               w_busy;
    logic               w_done;

    assign data = r_idx[DATA_MSB:DATA_LSB];
    assign sel  = r_idx[SEL_MSB:SEL_LSB];

    mux4_golden u_golden (
        .data (data),
        .sel  (sel),
        .y    (w_golden)
    );

    assign w_mismatch = (w_a != w_golden) | (w_b != w_golden);
    assign w_err_next = r_err + {{(CNT_W-1){1'b0}}, w_mismatch};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SETTLE;
            SETTLE:  if (r_timer == '0) w_next = SAMPLE;
            SAMPLE:  w_next = (r_idx == LAST_IDX) ? DONE : SETTLE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == SETTLE) || (r_state == SAMPLE);
        w_done = (r_state == DONE);
    end

    // pass is resolved on the final sample edge so it is already valid while done is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx     <= '0;
            r_timer   <= '0;
            r_err     <= '0;
            r_pass    <= 1'b0;
            r_ffvec   <= '0;
            r_ffvalid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_idx     <= '0;
                        r_timer   <= TMR_LOAD;
                        r_err     <= '0;
                        r_pass    <= 1'b0;
                        r_ffvec   <= '0;
                        r_ffvalid <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (r_timer != '0) r_timer <= r_timer - TMR_W'(1);
                end
                SAMPLE: begin
                    r_err <= w_err_next;
                    if (w_mismatch && !r_ffvalid) begin
                        r_ffvec   <= r_idx;
                        r_ffvalid <= 1'b1;
                    end
                    if (r_idx == LAST_IDX) begin
                        r_pass <= (w_err_next == '0);
                    end else begin
                        r_idx   <= r_idx + VEC_W'(1);
                        r_timer <= TMR_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy             = w_busy;
    assign done             = w_done;
    assign pass             = r_pass;
    assign err_count        = r_err;
    assign first_fail_vec   = r_ffvec;
    assign first_fail_valid = r_ffvalid;

endmodule : mux_sweep_checker
`default_nettype wire

// File: tb/tb_mux_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_sweep_checker
// Purpose  : Scoreboard bench for mux_sweep_checker with faulty mux models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_sweep_checker;

    localparam int S   = 4;
    localparam int PER = 64 * (S + 1);

    typedef struct {
        int   done_cyc;
        int   err;
        logic pass;
        logic ffvalid;
        int   ffv;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] data;
    logic [1:0] sel;
    logic       w_a;
    logic       w_b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [6:0] err_count;
    logic [5:0] first_fail_vec;
    logic       first_fail_valid;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   pops = 0;
    int   pushes = 0;
    int   mode = 0;
    exp_t q[$];

    logic       cur_g;
    logic [7:0] hist = '0;

    mux_sweep_checker #(.SETTLE_CYCLES(S), .CNT_W(7)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .data             (data),
        .sel              (sel),
        .w_a              (w_a),
        .w_b              (w_b),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .first_fail_vec   (first_fail_vec),
        .first_fail_valid (first_fail_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Mux models: mode 1 w_b stuck 0, mode 2 w_a inverted, modes 3/4 w_b delayed S-1/S+1.
    assign cur_g = data[sel];
    always @(posedge clk) hist <= {hist[6:0], cur_g};
    assign w_a = (mode == 2) ? ~cur_g : cur_g;
    always_comb begin
        w_b = cur_g;
        case (mode)
            1:       w_b = 1'b0;
            3:       w_b = hist[S-2];
            4:       w_b = hist[S];
            default: w_b = cur_g;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("done_cycle", cyc, e.done_cyc);
                check("err_count", 32'(err_count), e.err);
                check("pass", 32'(pass), 32'(e.pass));
                check("first_fail_valid", 32'(first_fail_valid), 32'(e.ffvalid));
                check("first_fail_vec", 32'(first_fail_vec), e.ffv);
                pops++;
            end
        end
    end

    task automatic push(input int dc, input int er, input logic ps, input logic fv, input int ffv);
        exp_t e;
        e.done_cyc = dc; e.err = er; e.pass = ps; e.ffvalid = fv; e.ffv = ffv;
        q.push_back(e);
        pushes++;
    endtask

    task automatic wait_pops(input int n);
        int t = 0;
        while (pops < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (pops < n) check("done_timeout", pops, n);
    endtask

    task automatic run_sweep(input int m, input int er, input logic ps, input logic fv,
                             input int ffv, input bit mid_pulse);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        push(cyc + PER, er, ps, fv, ffv);
        check("busy_after_start", 32'(busy), 32'd1);
        if (mid_pulse) begin
            repeat (100) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_pops(pushes);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_err"}, 32'(err_count), 32'd0);
        check({tag, "_ffv"}, 32'(first_fail_vec), 32'd0);
        check({tag, "_ffvalid"}, 32'(first_fail_valid), 32'd0);
        check({tag, "_vec"}, 32'({sel, data}), 32'd0);
    endtask

    initial begin
        int t;
        int acc;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        run_sweep(0, 0, 1'b1, 1'b0, 0, 1'b0);
        run_sweep(1, 32, 1'b0, 1'b1, 6'h01, 1'b0);
        run_sweep(2, 64, 1'b0, 1'b1, 6'h00, 1'b0);
        run_sweep(3, 0, 1'b1, 1'b0, 0, 1'b0);
        // Delay S+1 samples the previous vector's output: 29 transitions in
        // the 0..63 golden sequence plus vector 0 against the parked vector 63.
        run_sweep(4, 30, 1'b0, 1'b1, 6'h00, 1'b0);

        // Abort at vector 20 with errors already accumulated (w_b stuck 0).
        @(negedge clk);
        mode  = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while ({sel, data} != 6'd20 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("reach_vec20", 32'({sel, data}), 32'd20);
        check("pre_reset_err", 32'(err_count), 32'd10);
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        run_sweep(0, 0, 1'b1, 1'b0, 0, 1'b0);

        run_sweep(0, 0, 1'b1, 1'b0, 0, 1'b1);

        // Held start: DONE, one IDLE cycle, then the next accept edge.
        @(negedge clk);
        mode  = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        push(acc + PER, 0, 1'b1, 1'b0, 0);
        push(acc + PER + 2 + PER, 0, 1'b1, 1'b0, 0);
        wait_pops(pushes - 1);
        repeat (3) @(negedge clk);
        check("held_restart_busy", 32'(busy), 32'd1);
        start = 1'b0;
        wait_pops(pushes);

        repeat (5) @(negedge clk);
        check("queue_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mux_sweep_checker
`default_nettype wire
